// File: rtl/bit_serializer_pkg.sv
// -----------------------------------------------------------------------------
// bit_ser_pkg
// Shared definitions for the bit_serializer block:
//   - state_t : FSM state encoding (IDLE / SHIFT / PAR)
//   - DEFAULT_WIDTH : default parallel word width
//   - calc_cnt_w() : bit-counter width derived from the word width
// -----------------------------------------------------------------------------
package bit_ser_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_PAR   = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter holds WIDTH-1 down to 0, so $clog2(WIDTH) bits suffice.
    // The floor of 1 keeps the vector legal for the smallest word width.
    function automatic int calc_cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// -----------------------------------------------------------------------------
// bit_serializer_if
// Groups the parallel-in handshake and the serial-out stream.
//   din[WIDTH-1:0] : parallel word offered by upstream
//   din_valid      : upstream offers din this cycle
//   din_ready      : serializer accepts din at this edge if din_valid=1
//   a              : serial bit stream
//   a_valid        : a carries a frame bit this cycle
//   done           : one-cycle pulse on the final bit of a frame
// Modports:
//   master : upstream/source side (drives din, din_valid)
//   slave  : serializer side (drives din_ready, a, a_valid, done)
// -----------------------------------------------------------------------------
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             a;
    logic             a_valid;
    logic             done;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  a,
        input  a_valid,
        input  done
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output a,
        output a_valid,
        output done
    );
endinterface

// File: rtl/bit_serializer_parity.sv
// -----------------------------------------------------------------------------
// bit_ser_parity
// Registered even-parity (XOR reduction) of a word, captured when i_en is high.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   i_en      : capture enable (word accepted this edge)
//   i_din     : word to reduce
//   o_parity  : registered XOR of the last captured word
// Only instantiated when BIT_SERIALIZER_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module bit_ser_parity #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_parity
);
    logic r_parity;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (i_en) begin
            r_parity <= ^i_din;
        end
    end

    assign o_parity = r_parity;
endmodule

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
// Parallel-to-serial front end: accepts WIDTH-bit words on a valid/ready
// handshake and emits them one bit per clock on bus.a, qualified by
// bus.a_valid, with a done pulse on the final bit. Back-to-back words
// stream with no idle gap.
// Parameters:
//   WIDTH     : word width (>= 2)
//   MSB_FIRST : 1 = MSB first, 0 = LSB first
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : bit_serializer_if.slave (din/din_valid/din_ready/a/a_valid/done)
// Build option:
//   BIT_SERIALIZER_PARITY_EN : append an even-parity bit (PAR state) to every
//   frame; done moves from the last data bit to the parity bit.
// -----------------------------------------------------------------------------
module bit_serializer
    import bit_ser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    bit_serializer_if.slave      bus
);
    localparam int CNT_W = calc_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_sreg;
    logic [WIDTH-1:0]   w_sreg_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_sbit;
    logic               w_ready;
    logic               w_accept;
    logic               w_a;
    logic               w_a_valid;
    logic               w_done;
    logic               w_last;

    // Bit currently presented and the register after one shift; the vacated
    // end fills with zero so a drained register never leaks stale data.
    generate
        if (MSB_FIRST) begin : g_msb
            assign w_sbit       = r_sreg[WIDTH-1];
            assign w_sreg_shift = {r_sreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign w_sbit       = r_sreg[0];
            assign w_sreg_shift = {1'b0, r_sreg[WIDTH-1:1]};
        end
    endgenerate

    assign w_last   = (r_cnt == '0);
    assign w_accept = bus.din_valid & w_ready;

`ifdef BIT_SERIALIZER_PARITY_EN
    logic w_parity;

    bit_ser_parity #(
        .WIDTH (WIDTH)
    ) u_parity (
        .clk      (clk),
        .reset    (reset),
        .i_en     (w_accept),
        .i_din    (bus.din),
        .o_parity (w_parity)
    );
`endif

    // Next state and Moore outputs. w_ready depends only on registered state,
    // so the accept path never feeds back into the outputs.
    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_a          = 1'b0;
        w_a_valid    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (bus.din_valid) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_a       = w_sbit;
                w_a_valid = 1'b1;
                if (w_last) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    w_state_next = S_PAR;
`else
                    // Last data bit doubles as the reload slot for the next
                    // word, which is what makes framing gapless.
                    w_done       = 1'b1;
                    w_ready      = 1'b1;
                    w_state_next = bus.din_valid ? S_SHIFT : S_IDLE;
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            S_PAR: begin
                w_a          = w_parity;
                w_a_valid    = 1'b1;
                w_done       = 1'b1;
                w_ready      = 1'b1;
                w_state_next = bus.din_valid ? S_SHIFT : S_IDLE;
            end
`endif
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_sreg <= bus.din;
                r_cnt  <= CNT_LOAD;
            end else if (r_state == S_SHIFT) begin
                r_sreg <= w_sreg_shift;
                // Saturate at zero; the counter is only reloaded on accept.
                if (!w_last) begin
                    r_cnt <= r_cnt - CNT_W'(1);
                end
            end else if (w_state_next == S_IDLE) begin
                r_cnt <= '0;
            end
        end
    end

    assign bus.din_ready = w_ready;
    assign bus.a         = w_a;
    assign bus.a_valid   = w_a_valid;
    assign bus.done      = w_done;
endmodule
